// File: rtl/xnorator_pkg.sv
// Shared types and width helpers for the XNOR engine, so the PE array and the
// accumulator always derive identical operand widths from the same parameters.
package xnorator_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OUTPUT
    } acc_state_e;

    function automatic int pe_width(input int tp);
        return $clog2(tp) + 1;
    endfunction

    function automatic int acc_width(input int tp, input int max_tiles);
        return $clog2(tp) + $clog2(max_tiles) + 2;
    endfunction

    function automatic int cnt_width(input int max_tiles);
        return $clog2(max_tiles) + 1;
    endfunction

endpackage

// File: rtl/xnor_accumulator.sv
// Accumulates num_tiles signed per-tile partial sums into one dot-product sum
// and binarizes it against a threshold latched at start.
module xnor_accumulator
    import xnorator_pkg::*;
#(
    parameter int  TP        = 8,
    parameter int  MAX_TILES = 256,
    localparam int PeWidth   = pe_width(TP),
    localparam int CntWidth  = cnt_width(MAX_TILES),
    localparam int AccWidth  = acc_width(TP, MAX_TILES)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic [CntWidth-1:0]        num_tiles_i,
    input  logic signed [AccWidth-1:0] threshold_i,
    input  logic                       pe_valid_i,
    input  logic signed [PeWidth-1:0]  pe_result_i,
    output logic                       pe_ready_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic signed [AccWidth-1:0] out_sum_o,
    output logic                       out_bit_o,
    output logic                       busy_o
);

    acc_state_e                 r_state;
    acc_state_e                 w_state_next;
    logic signed [AccWidth-1:0] r_acc;
    logic [CntWidth-1:0]        r_cnt;
    logic [CntWidth-1:0]        r_num_tiles;
    logic signed [AccWidth-1:0] r_threshold;
    logic signed [AccWidth-1:0] r_sum;
    logic                       r_bit;

    logic                       w_start_ok;
    logic                       w_load;
    logic                       w_beat;
    logic                       w_last;
    logic signed [AccWidth-1:0] w_pe_ext;
    logic signed [AccWidth-1:0] w_acc_next;

    assign w_pe_ext   = {{(AccWidth-PeWidth){pe_result_i[PeWidth-1]}}, pe_result_i};
    assign w_acc_next = r_acc + w_pe_ext;
    assign w_start_ok = start_i && (num_tiles_i != '0);
    assign w_beat     = pe_valid_i && (r_state == ACCUM);
    assign w_last     = w_beat && (r_cnt == r_num_tiles - CntWidth'(1));
    // A new job may launch from IDLE or on the very cycle the result drains.
    assign w_load     = w_start_ok &&
                        ((r_state == IDLE) || ((r_state == OUTPUT) && out_ready_i));

    // NOTE: every output of a combinational process gets a default first, so
    // no branch can leave it unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_start_ok) w_state_next = ACCUM;
            ACCUM:   if (w_last)     w_state_next = OUTPUT;
            OUTPUT:  if (out_ready_i) w_state_next = w_start_ok ? ACCUM : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_num_tiles <= '0;
            r_threshold <= '0;
            r_sum       <= '0;
            r_bit       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_num_tiles <= num_tiles_i;
                r_threshold <= threshold_i;
                r_acc       <= '0;
                r_cnt       <= '0;
            end else if (w_beat) begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + CntWidth'(1);
            end
            // Result registers hold their value after the handshake.
            if (w_last) begin
                r_sum <= w_acc_next;
                r_bit <= (w_acc_next >= r_threshold);
            end
        end
    end

    assign pe_ready_o  = (r_state == ACCUM);
    assign out_valid_o = (r_state == OUTPUT);
    assign busy_o      = (r_state != IDLE);
    assign out_sum_o   = r_sum;
    assign out_bit_o   = r_bit;

endmodule

// File: tb/tb_xnor_accumulator.sv
// Self-checking bench for xnor_accumulator: directed vector table, multi-cycle
// corner sequences and randomized jobs checked against an arithmetic model.
module tb_xnor_accumulator;
    import xnorator_pkg::*;

    localparam int TP        = 8;
    localparam int MAX_TILES = 256;
    localparam int PE_W      = pe_width(TP);
    localparam int CNT_W     = cnt_width(MAX_TILES);
    localparam int ACC_W     = acc_width(TP, MAX_TILES);

    logic                    clk_i = 1'b0;
    logic                    rst_ni;
    logic                    start_i;
    logic [CNT_W-1:0]        num_tiles_i;
    logic signed [ACC_W-1:0] threshold_i;
    logic                    pe_valid_i;
    logic signed [PE_W-1:0]  pe_result_i;
    logic                    pe_ready_o;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic signed [ACC_W-1:0] out_sum_o;
    logic                    out_bit_o;
    logic                    busy_o;

    int n_checks = 0;
    int n_errors = 0;
    int beat_q[$];
    int gap_q[$];

    xnor_accumulator #(.TP(TP), .MAX_TILES(MAX_TILES)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .num_tiles_i (num_tiles_i),
        .threshold_i (threshold_i),
        .pe_valid_i  (pe_valid_i),
        .pe_result_i (pe_result_i),
        .pe_ready_o  (pe_ready_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_sum_o   (out_sum_o),
        .out_bit_o   (out_bit_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int n;
        int thr;
        int v0, v1, v2;
        int g0, g1, g2;
        int rdly;
        int exp_sum;
        int exp_bit;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_run(input int n, input int thr);
        start_i     = 1'b1;
        num_tiles_i = CNT_W'(n);
        threshold_i = ACC_W'(thr);
        tick();
        start_i = 1'b0;
    endtask

    task automatic feed();
        foreach (beat_q[i]) begin
            int w;
            pe_valid_i = 1'b0;
            repeat (gap_q[i]) tick();
            pe_valid_i  = 1'b1;
            pe_result_i = PE_W'(beat_q[i]);
            w = 0;
            while (!pe_ready_o && w < 8) begin
                tick();
                w++;
            end
            if (w == 8) check("pe_ready wait", int'(pe_ready_o), 1);
            tick();
        end
        pe_valid_i = 1'b0;
    endtask

    task automatic collect(input int rdly, input int exp_sum, input int exp_bit, input string tag);
        check({tag, " valid latency"}, int'(out_valid_o), 1);
        check({tag, " sum"}, int'(out_sum_o), exp_sum);
        check({tag, " bit"}, int'(out_bit_o), exp_bit);
        repeat (rdly) begin
            out_ready_i = 1'b0;
            tick();
            check({tag, " hold valid"}, int'(out_valid_o), 1);
            check({tag, " hold sum"}, int'(out_sum_o), exp_sum);
            check({tag, " hold pe_ready"}, int'(pe_ready_o), 0);
        end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check({tag, " valid drop"}, int'(out_valid_o), 0);
        check({tag, " sum kept"}, int'(out_sum_o), exp_sum);
    endtask

    vec_t vecs[6];

    initial begin
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        num_tiles_i = '0;
        threshold_i = '0;
        pe_valid_i  = 1'b0;
        pe_result_i = '0;
        out_ready_i = 1'b0;
        tick();
        tick();
        check("reset busy", int'(busy_o), 0);
        check("reset pe_ready", int'(pe_ready_o), 0);
        check("reset out_valid", int'(out_valid_o), 0);
        check("reset out_sum", int'(out_sum_o), 0);
        rst_ni = 1'b1;
        tick();

        vecs[0] = '{n:3, thr:6,    v0:3,  v1:-2, v2:5,  g0:0, g1:0, g2:0, rdly:0, exp_sum:6,   exp_bit:1};
        vecs[1] = '{n:3, thr:7,    v0:3,  v1:-2, v2:5,  g0:0, g1:0, g2:0, rdly:0, exp_sum:6,   exp_bit:0};
        vecs[2] = '{n:3, thr:6,    v0:3,  v1:-2, v2:5,  g0:0, g1:2, g2:0, rdly:4, exp_sum:6,   exp_bit:1};
        vecs[3] = '{n:1, thr:4,    v0:4,  v1:0,  v2:0,  g0:1, g1:0, g2:0, rdly:1, exp_sum:4,   exp_bit:1};
        vecs[4] = '{n:2, thr:-1,   v0:-8, v1:7,  v2:0,  g0:0, g1:1, g2:0, rdly:2, exp_sum:-1,  exp_bit:1};
        vecs[5] = '{n:3, thr:-100, v0:-8, v1:-8, v2:-8, g0:0, g1:0, g2:3, rdly:0, exp_sum:-24, exp_bit:1};

        for (int k = 0; k < 6; k++) begin
            beat_q = {};
            gap_q  = {};
            beat_q.push_back(vecs[k].v0); gap_q.push_back(vecs[k].g0);
            if (vecs[k].n > 1) begin beat_q.push_back(vecs[k].v1); gap_q.push_back(vecs[k].g1); end
            if (vecs[k].n > 2) begin beat_q.push_back(vecs[k].v2); gap_q.push_back(vecs[k].g2); end
            start_run(vecs[k].n, vecs[k].thr);
            check($sformatf("vec%0d busy", k), int'(busy_o), 1);
            feed();
            collect(vecs[k].rdly, vecs[k].exp_sum, vecs[k].exp_bit, $sformatf("vec%0d", k));
        end

        // num_tiles == 0 is ignored
        start_run(0, 0);
        check("zero tiles busy", int'(busy_o), 0);
        check("zero tiles pe_ready", int'(pe_ready_o), 0);
        tick();
        check("zero tiles busy later", int'(busy_o), 0);

        // start pulsed mid-accumulation must be ignored
        start_run(3, 6);
        beat_q = {3}; gap_q = {0};
        feed();
        start_i     = 1'b1;
        num_tiles_i = CNT_W'(1);
        threshold_i = ACC_W'(-50);
        tick();
        start_i = 1'b0;
        check("start in accum pe_ready", int'(pe_ready_o), 1);
        beat_q = {-2, 5}; gap_q = {0, 0};
        feed();
        collect(0, 6, 1, "start in accum");

        // full-length runs at both extremes
        beat_q = {}; gap_q = {};
        for (int i = 0; i < MAX_TILES; i++) begin beat_q.push_back(7); gap_q.push_back(0); end
        start_run(MAX_TILES, 0);
        feed();
        collect(0, 1792, 1, "max +7");
        beat_q = {}; gap_q = {};
        for (int i = 0; i < MAX_TILES; i++) begin beat_q.push_back(-8); gap_q.push_back(0); end
        start_run(MAX_TILES, 0);
        feed();
        collect(0, -2048, 0, "max -8");

        // reset mid-run clears everything and leaves no residue
        start_run(3, 0);
        beat_q = {3, -2}; gap_q = {0, 0};
        feed();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        check("abort busy", int'(busy_o), 0);
        check("abort pe_ready", int'(pe_ready_o), 0);
        check("abort out_valid", int'(out_valid_o), 0);
        check("abort out_sum", int'(out_sum_o), 0);
        check("abort out_bit", int'(out_bit_o), 0);
        start_run(1, 0);
        beat_q = {4}; gap_q = {0};
        feed();
        collect(0, 4, 1, "after abort");

        // back-to-back: new start on the output handshake cycle
        start_run(2, 0);
        beat_q = {1, 1}; gap_q = {0, 0};
        feed();
        check("b2b first sum", int'(out_sum_o), 2);
        out_ready_i = 1'b1;
        start_i     = 1'b1;
        num_tiles_i = CNT_W'(2);
        threshold_i = ACC_W'(100);
        tick();
        out_ready_i = 1'b0;
        start_i     = 1'b0;
        check("b2b pe_ready", int'(pe_ready_o), 1);
        check("b2b out_valid", int'(out_valid_o), 0);
        beat_q = {-3, -3}; gap_q = {0, 0};
        feed();
        collect(0, -6, 0, "b2b second");

        // randomized jobs against an arithmetic model
        for (int r = 0; r < 25; r++) begin
            int n, thr, sum, rdly;
            n    = int'($urandom_range(1, 12));
            thr  = int'($urandom_range(0, 60)) - 30;
            rdly = int'($urandom_range(0, 3));
            sum  = 0;
            beat_q = {}; gap_q = {};
            for (int i = 0; i < n; i++) begin
                int v;
                v = int'($urandom_range(0, 15)) - 8;
                sum += v;
                beat_q.push_back(v);
                gap_q.push_back(int'($urandom_range(0, 2)));
            end
            start_run(n, thr);
            feed();
            collect(rdly, sum, (sum >= thr) ? 1 : 0, $sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
